// File: rtl/pc_sequencer.sv
// Instruction sequencer feeding the program counter: fetch, decode, execute
// one 16-bit instruction at a time and issue a single PC command per instruction.
module pc_sequencer #(
    parameter int IW          = 16,
    parameter int AW          = 8,
    parameter int ALU_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] mem_dout,
    input  logic          alu_done,
    input  logic          alu_zero,
    output logic          pc_inc,
    output logic          pc_jmp,
    output logic          pc_call,
    output logic          pc_ret,
    output logic [AW-1:0] pc_addr,
    output logic          alu_start,
    output logic [3:0]    alu_op,
    output logic [AW-1:0] alu_operand,
    output logic          halted,
    output logic [2:0]    err
);

    localparam int CW = $clog2(ALU_TIMEOUT);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ALU  = 4'h1;
    localparam logic [3:0] OP_JMP  = 4'h2;
    localparam logic [3:0] OP_JMPZ = 4'h3;
    localparam logic [3:0] OP_CALL = 4'h4;
    localparam logic [3:0] OP_RET  = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WAIT,
        S_HALT
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ir_q, ir_d;
    logic          zflag_q, zflag_d;
    logic          call_q, call_d;
    logic [2:0]    err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    opc;

    assign opc         = ir_q[IW-1:IW-4];
    assign alu_op      = ir_q[11:8];
    assign alu_operand = ir_q[AW-1:0];
    assign halted      = (state_q == S_HALT);
    assign err         = err_q;

    // Pulses are decoded from the registered state so each lasts exactly one cycle.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        zflag_d   = zflag_q;
        call_d    = call_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        pc_inc    = 1'b0;
        pc_jmp    = 1'b0;
        pc_call   = 1'b0;
        pc_ret    = 1'b0;
        pc_addr   = '0;
        alu_start = 1'b0;
        unique case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = mem_dout;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opc)
                    OP_NOP: pc_inc = 1'b1;
                    OP_ALU: begin
                        alu_start = 1'b1;
                        cnt_d     = '0;
                        state_d   = S_WAIT;
                    end
                    OP_JMP: begin
                        pc_jmp  = 1'b1;
                        pc_addr = ir_q[AW-1:0];
                    end
                    OP_JMPZ: begin
                        if (zflag_q) begin
                            pc_jmp  = 1'b1;
                            pc_addr = ir_q[AW-1:0];
                        end else begin
                            pc_inc = 1'b1;
                        end
                    end
                    OP_CALL: begin
                        pc_call = 1'b1;
                        pc_addr = ir_q[AW-1:0];
                        if (call_q) err_d[1] = 1'b1;
                        call_d = 1'b1;
                    end
                    OP_RET: begin
                        pc_ret = 1'b1;
                        if (!call_q) err_d[1] = 1'b1;
                        call_d = 1'b0;
                    end
                    OP_HALT: state_d = S_HALT;
                    default: begin
                        pc_inc   = 1'b1;
                        err_d[0] = 1'b1;
                    end
                endcase
            end
            S_WAIT: begin
                if (alu_done) begin
                    zflag_d = alu_zero;
                    pc_inc  = 1'b1;
                    state_d = S_FETCH;
                end else if (cnt_q == CW'(ALU_TIMEOUT - 1)) begin
                    pc_inc   = 1'b1;
                    err_d[2] = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            zflag_q <= 1'b0;
            call_q  <= 1'b0;
            err_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            zflag_q <= zflag_d;
            call_q  <= call_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: behavioural PC/memory around the DUT plus an
// instruction-level timeline model checked every cycle.
module tb_pc_sequencer;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mem_dout;
    logic        alu_done = 1'b0;
    logic        alu_zero = 1'b0;
    logic        pc_inc, pc_jmp, pc_call, pc_ret;
    logic [7:0]  pc_addr;
    logic        alu_start;
    logic [3:0]  alu_op;
    logic [7:0]  alu_operand;
    logic        halted;
    logic [2:0]  err;

    pc_sequencer #(.IW(16), .AW(8), .ALU_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .mem_dout(mem_dout),
        .alu_done(alu_done), .alu_zero(alu_zero),
        .pc_inc(pc_inc), .pc_jmp(pc_jmp), .pc_call(pc_call),
        .pc_ret(pc_ret), .pc_addr(pc_addr), .alu_start(alu_start),
        .alu_op(alu_op), .alu_operand(alu_operand),
        .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];
    logic [7:0]  pc_q, ret_q;

    // Program counter with a single return register
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= 8'h00;
            ret_q <= 8'h00;
        end else if (pc_inc) begin
            pc_q <= pc_q + 8'd1;
        end else if (pc_jmp) begin
            pc_q <= pc_addr;
        end else if (pc_call) begin
            ret_q <= pc_q + 8'd1;
            pc_q  <= pc_addr;
        end else if (pc_ret) begin
            pc_q <= ret_q;
        end
    end

    always @(posedge clk) mem_dout <= mem[pc_q];

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int epoch = 0;

    always @(negedge rst_n) epoch++;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    // Expected outputs for the current cycle
    logic       e_inc, e_jmp, e_call, e_ret, e_start, e_halt;
    logic [7:0] e_addr, e_opnd;
    logic [3:0] e_op;
    logic [2:0] e_err;

    logic [2:0]  m_err;
    logic [7:0]  m_pc, m_ret;
    logic        m_zf, m_call;
    logic [15:0] m_ir;
    int          my_ep;

    task automatic tick(output bit ab);
        @(posedge clk);
        #2;
        {e_inc, e_jmp, e_call, e_ret, e_start} = '0;
        e_addr = 8'h00;
        e_err  = m_err;
        e_op   = m_ir[11:8];
        e_opnd = m_ir[7:0];
        ab = (epoch != my_ep);
    endtask

    initial begin : model
        bit ab;
        logic [3:0] op;
        logic [7:0] a;
        wait (epoch != 0);
        forever begin
            m_err = 0; m_pc = 0; m_ret = 0;
            m_zf = 0; m_call = 0; m_ir = 0;
            {e_inc, e_jmp, e_call, e_ret, e_start, e_halt} = '0;
            e_addr = 0; e_opnd = 0; e_op = 0; e_err = 0;
            wait (rst_n === 1'b1);
            my_ep = epoch;
            ab = 0;
            while (!ab) begin
                tick(ab);
                if (ab) break;
                tick(ab);
                if (ab) break;
                m_ir = mem[m_pc];
                op = m_ir[15:12];
                a = m_ir[7:0];
                e_op = m_ir[11:8];
                e_opnd = a;
                case (op)
                    4'h0: begin e_inc = 1; m_pc++; end
                    4'h1: e_start = 1;
                    4'h2: begin e_jmp = 1; e_addr = a; m_pc = a; end
                    4'h3: begin
                        if (m_zf) begin
                            e_jmp = 1; e_addr = a; m_pc = a;
                        end else begin
                            e_inc = 1; m_pc++;
                        end
                    end
                    4'h4: begin
                        e_call = 1; e_addr = a;
                        if (m_call) m_err[1] = 1;
                        m_call = 1;
                        m_ret = m_pc + 8'd1;
                        m_pc = a;
                    end
                    4'h5: begin
                        e_ret = 1;
                        if (!m_call) m_err[1] = 1;
                        m_call = 0;
                        m_pc = m_ret;
                    end
                    4'hF: ;
                    default: begin e_inc = 1; m_err[0] = 1; m_pc++; end
                endcase
                if (op == 4'h1) begin
                    for (int n = 0; !ab; n++) begin
                        tick(ab);
                        if (ab) break;
                        if (alu_done) begin
                            e_inc = 1; m_zf = alu_zero; m_pc++;
                            break;
                        end
                        if (n == TO - 1) begin
                            e_inc = 1; m_err[2] = 1; m_pc++;
                            break;
                        end
                    end
                end
                if (op == 4'hF) begin
                    while (!ab) begin
                        tick(ab);
                        if (!ab) e_halt = 1;
                    end
                end
                if (!ab) tick(ab);
            end
        end
    end

    // Event log for hand-computed expectations
    int         first_inc, first_jmp, first_call, first_ret, start_cyc;
    int         n_start, n_jmp, n_inc, n_pulse, done_cyc;
    logic [7:0] jmp_addr, call_addr, done_opnd;
    logic [3:0] done_op;

    initial begin : compare
        int ones;
        forever begin
            @(negedge clk);
            if (epoch == 0) continue;
            if (rst_n !== 1'b1) begin
                cyc = 0;
                first_inc = 0; first_jmp = 0; first_call = 0;
                first_ret = 0; start_cyc = 0; n_start = 0; n_jmp = 0;
                n_inc = 0; n_pulse = 0; done_cyc = 0;
                jmp_addr = 0; call_addr = 0; done_op = 0; done_opnd = 0;
                check("reset_outputs",
                      {pc_inc, pc_jmp, pc_call, pc_ret, pc_addr, alu_start,
                       alu_op, alu_operand, halted, err}, 0);
            end else begin
                cyc++;
                check("pc_inc", pc_inc, e_inc);
                check("pc_jmp", pc_jmp, e_jmp);
                check("pc_call", pc_call, e_call);
                check("pc_ret", pc_ret, e_ret);
                check("pc_addr", pc_addr, e_addr);
                check("alu_start", alu_start, e_start);
                check("alu_op", alu_op, e_op);
                check("alu_operand", alu_operand, e_opnd);
                check("halted", halted, e_halt);
                check("err", err, e_err);
                ones = $countones({pc_inc, pc_jmp, pc_call, pc_ret});
                check("single_pulse", ones <= 1, 1);
                n_pulse += ones;
                if (pc_inc) begin
                    n_inc++;
                    if (first_inc == 0) first_inc = cyc;
                    if (start_cyc > 0 && done_cyc == 0) begin
                        done_cyc = cyc; done_op = alu_op;
                        done_opnd = alu_operand;
                    end
                end
                if (pc_jmp) begin
                    n_jmp++;
                    if (first_jmp == 0) begin
                        first_jmp = cyc; jmp_addr = pc_addr;
                    end
                end
                if (pc_call && first_call == 0) begin
                    first_call = cyc; call_addr = pc_addr;
                end
                if (pc_ret && first_ret == 0) first_ret = cyc;
                if (alu_start) begin
                    n_start++;
                    if (start_cyc == 0) start_cyc = cyc;
                end
            end
        end
    end

    int dmode = 0;
    bit zval = 0;

    initial begin : stim_alu
        forever begin
            @(posedge clk);
            #1;
            case (dmode)
                0: begin
                    alu_done = ($urandom_range(0, 3) == 0);
                    alu_zero = $urandom_range(0, 1) == 1;
                end
                1: alu_done = 1'b0;
                default: begin
                    alu_done = (start_cyc > 0) && (cyc + 1 == start_cyc + 4);
                    alu_zero = zval;
                end
            endcase
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run(input int n);
        do_reset();
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    endtask

    initial begin : main
        logic [3:0] op;
        int r;
        rst_n = 1'b1;

        fill_halt();
        mem[0] = 16'h7000; mem[1] = 16'h1000;
        dmode = 1;
        do_reset();
        repeat (8) @(posedge clk);
        #3;
        check("t1_err_before", err, 3'b001);
        check("t1_pc_before", pc_q, 1);
        rst_n = 1'b0;
        #1;
        check("t1_rst_pulses", {pc_inc, alu_start, halted}, 0);
        check("t1_rst_err", err, 0);
        check("t1_rst_pc", pc_q, 0);

        fill_halt();
        mem[0] = 16'h0000; mem[1] = 16'h2040;
        run(20);
        check("t2_inc_cyc", first_inc, 3);
        check("t2_jmp_cyc", first_jmp, 6);
        check("t2_jmp_addr", jmp_addr, 8'h40);
        check("t2_halted", halted, 1);

        fill_halt();
        mem[0] = 16'h1305; mem[1] = 16'h3010;
        dmode = 2; zval = 1;
        run(20);
        check("t3_start_cnt", n_start, 1);
        check("t3_done_cyc", done_cyc, 7);
        check("t3_alu_op", done_op, 4'h3);
        check("t3_operand", done_opnd, 8'h05);
        check("t3_jmpz_cyc", first_jmp, 10);
        check("t3_jmpz_addr", jmp_addr, 8'h10);
        zval = 0;
        run(20);
        check("t3b_no_jmp", n_jmp, 0);
        check("t3b_incs", n_inc, 2);
        check("t3b_pc", pc_q, 2);

        fill_halt();
        mem[0] = 16'h1000;
        dmode = 1;
        run(30);
        check("t4_timeout_cyc", first_inc, 3 + 16);
        check("t4_err", err, 3'b100);

        fill_halt();
        mem[0] = 16'h4020; mem[8'h20] = 16'h5000;
        run(20);
        check("t5_call_cyc", first_call, 3);
        check("t5_call_addr", call_addr, 8'h20);
        check("t5_ret_cyc", first_ret, 6);
        check("t5_err", err, 0);
        check("t5_pc", pc_q, 1);
        fill_halt();
        mem[0] = 16'h4020; mem[8'h20] = 16'h4030;
        run(20);
        check("t5b_nest_err", err, 3'b010);
        fill_halt();
        mem[0] = 16'h5000;
        run(12);
        check("t5c_ret_cyc", first_ret, 3);
        check("t5c_ret_err", err, 3'b010);

        fill_halt();
        mem[0] = 16'h7000;
        run(60);
        check("t6_err", err, 3'b001);
        check("t6_halted", halted, 1);
        check("t6_pulses", n_pulse, 1);

        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 256; i++) begin
                r = $urandom_range(0, 15);
                if (r < 3) op = 4'h0;
                else if (r < 6) op = 4'h1;
                else if (r < 8) op = 4'h2;
                else if (r < 10) op = 4'h3;
                else if (r < 12) op = 4'h4;
                else if (r < 14) op = 4'h5;
                else if (r == 14) op = 4'($urandom_range(6, 14));
                else op = ($urandom_range(0, 7) == 0) ? 4'hF : 4'h0;
                mem[i] = {op, 4'($urandom), 8'($urandom)};
            end
            dmode = (it == 3) ? 1 : 0;
            run(1500);
        end

        rst_n = 1'b0;
        #20;
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
